// File: rtl/tx_arbiter.sv
// tx_arbiter
//   Round-robin arbiter between two packet sources (A: command responses,
//   B: async events) feeding a single transmitter. It validates the length of
//   the granted packet and either writes it to the transmitter or rejects it.
//   After each write it spaces the next write until the transmitter is idle.
//
// Ports
//   clk             sole clock, rising edge
//   rst             asynchronous active-low reset
//   a_req / b_req   packet request, held by the requester until ack or err
//   a_len / b_len   payload length in bytes
//   a_buf / b_buf   payload, byte k in bits [8k+7:8k]
//   a_ack / b_ack   one-cycle pulse: packet accepted and written
//   a_err / b_err   one-cycle pulse: packet rejected (bad length)
//   tx_busy         transmitter is serialising a packet
//   tx_packet_wr    one-cycle write strobe to the transmitter
//   tx_payload_len  registered length of the last written packet
//   tx_buf          registered payload of the last written packet, bytes >= len zeroed
//   tx_count        packets written since reset (wraps)
//   drop_count      packets rejected since reset (wraps)
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | arbitrate when tx_busy=0; write or reject the granted packet
// GAP   | one cycle after a write, tx_busy ignored
// WAIT  | hold off until the transmitter reports idle
module tx_arbiter #(
  parameter int MAX_LEN = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_req,
  input  logic         b_req,
  input  logic [7:0]   a_len,
  input  logic [7:0]   b_len,
  input  logic [127:0] a_buf,
  input  logic [127:0] b_buf,
  output logic         a_ack,
  output logic         b_ack,
  output logic         a_err,
  output logic         b_err,
  input  logic         tx_busy,
  output logic         tx_packet_wr,
  output logic [7:0]   tx_payload_len,
  output logic [127:0] tx_buf,
  output logic [15:0]  tx_count,
  output logic [7:0]   drop_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Wider than the length field so a large MAX_LEN cannot truncate the compare.
  localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);

  state_t         state_q, state_d;
  logic           last_grant_q, last_grant_d;  // 1 = B granted last
  logic           tx_packet_wr_q, tx_packet_wr_d;
  logic           a_ack_q, a_ack_d;
  logic           b_ack_q, b_ack_d;
  logic           a_err_q, a_err_d;
  logic           b_err_q, b_err_d;
  logic [7:0]     tx_payload_len_q, tx_payload_len_d;
  logic [127:0]   tx_buf_q, tx_buf_d;
  logic [15:0]    tx_count_q, tx_count_d;
  logic [7:0]     drop_count_q, drop_count_d;

  logic           grant_b;
  logic [7:0]     sel_len;
  logic [127:0]   sel_buf;
  logic [127:0]   masked_buf;
  logic           len_ok;
  logic           can_arb;

  // Grant selection and payload shaping for whichever requester would win now.
  always_comb begin
    grant_b    = b_req && (!a_req || !last_grant_q);
    sel_len    = grant_b ? b_len : a_len;
    sel_buf    = grant_b ? b_buf : a_buf;
    len_ok     = (sel_len != 8'd0) && ({1'b0, sel_len} <= MAX_LEN_W);
    masked_buf = '0;
    for (int k = 0; k < 16; k++) begin
      if (k < int'(sel_len)) begin
        masked_buf[8*k +: 8] = sel_buf[8*k +: 8];
      end
    end
  end

  // A rejected requester still shows its request during the err cycle, so
  // arbitration skips that cycle to avoid rejecting the same packet twice.
  assign can_arb = !tx_busy && !a_err_q && !b_err_q && (a_req || b_req);

  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    tx_packet_wr_d   = 1'b0;
    a_ack_d          = 1'b0;
    b_ack_d          = 1'b0;
    a_err_d          = 1'b0;
    b_err_d          = 1'b0;
    tx_payload_len_d = tx_payload_len_q;
    tx_buf_d         = tx_buf_q;
    tx_count_d       = tx_count_q;
    drop_count_d     = drop_count_q;

    case (state_q)
      IDLE: begin
        if (can_arb) begin
          last_grant_d = grant_b;
          if (len_ok) begin
            tx_packet_wr_d   = 1'b1;
            a_ack_d          = !grant_b;
            b_ack_d          = grant_b;
            tx_payload_len_d = sel_len;
            tx_buf_d         = masked_buf;
            tx_count_d       = tx_count_q + 16'd1;
            state_d          = GAP;
          end else begin
            a_err_d      = !grant_b;
            b_err_d      = grant_b;
            drop_count_d = drop_count_q + 8'd1;
          end
        end
      end
      GAP: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      last_grant_q     <= 1'b1;
      tx_packet_wr_q   <= 1'b0;
      a_ack_q          <= 1'b0;
      b_ack_q          <= 1'b0;
      a_err_q          <= 1'b0;
      b_err_q          <= 1'b0;
      tx_payload_len_q <= 8'd0;
      tx_buf_q         <= '0;
      tx_count_q       <= 16'd0;
      drop_count_q     <= 8'd0;
    end else begin
      state_q          <= state_d;
      last_grant_q     <= last_grant_d;
      tx_packet_wr_q   <= tx_packet_wr_d;
      a_ack_q          <= a_ack_d;
      b_ack_q          <= b_ack_d;
      a_err_q          <= a_err_d;
      b_err_q          <= b_err_d;
      tx_payload_len_q <= tx_payload_len_d;
      tx_buf_q         <= tx_buf_d;
      tx_count_q       <= tx_count_d;
      drop_count_q     <= drop_count_d;
    end
  end

  assign tx_packet_wr   = tx_packet_wr_q;
  assign a_ack          = a_ack_q;
  assign b_ack          = b_ack_q;
  assign a_err          = a_err_q;
  assign b_err          = b_err_q;
  assign tx_payload_len = tx_payload_len_q;
  assign tx_buf         = tx_buf_q;
  assign tx_count       = tx_count_q;
  assign drop_count     = drop_count_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed testbench for tx_arbiter: linear stimulus, hand-computed expectations.
module tb_tx_arbiter;

  logic         clk;
  logic         rst;
  logic         a_req, b_req;
  logic [7:0]   a_len, b_len;
  logic [127:0] a_buf, b_buf;
  logic         a_ack, b_ack, a_err, b_err;
  logic         tx_busy;
  logic         tx_packet_wr;
  logic [7:0]   tx_payload_len;
  logic [127:0] tx_buf;
  logic [15:0]  tx_count;
  logic [7:0]   drop_count;

  int n_cmp = 0;
  int n_bad = 0;

  tx_arbiter #(.MAX_LEN(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .a_req          (a_req),
    .b_req          (b_req),
    .a_len          (a_len),
    .b_len          (b_len),
    .a_buf          (a_buf),
    .b_buf          (b_buf),
    .a_ack          (a_ack),
    .b_ack          (b_ack),
    .a_err          (a_err),
    .b_err          (b_err),
    .tx_busy        (tx_busy),
    .tx_packet_wr   (tx_packet_wr),
    .tx_payload_len (tx_payload_len),
    .tx_buf         (tx_buf),
    .tx_count       (tx_count),
    .drop_count     (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pulses();
    return 128'({a_ack, b_ack, a_err, b_err});
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr"},    128'(tx_packet_wr), 128'(0));
    chk({tag, "_pulse"}, pulses(), 128'(0));
    chk({tag, "_len"},   128'(tx_payload_len), 128'(0));
    chk({tag, "_buf"},   tx_buf, 128'(0));
    chk({tag, "_txc"},   128'(tx_count), 128'(0));
    chk({tag, "_drop"},  128'(drop_count), 128'(0));
  endtask

  initial begin
    rst = 1'b0; a_req = 0; b_req = 0; a_len = 0; b_len = 0;
    a_buf = '0; b_buf = '0; tx_busy = 1'b0;

    // Reset state, with A already requesting: no grant while in reset.
    a_req = 1; a_len = 8'd1; a_buf = {16{8'h81}};
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b1;
    chk("no_grant_before_edge", 128'(tx_packet_wr), 128'(0));

    // Single byte from A; upper bytes must be masked.
    tick();
    chk("a1_wr",    128'(tx_packet_wr), 128'(1));
    chk("a1_pulse", pulses(), 128'(4'b1000));
    chk("a1_len",   128'(tx_payload_len), 128'(1));
    chk("a1_buf",   tx_buf, 128'h81);
    chk("a1_txc",   128'(tx_count), 128'(1));
    a_req = 0;
    tick();
    chk("a1_wr_clear",    128'(tx_packet_wr), 128'(0));
    chk("a1_pulse_clear", pulses(), 128'(0));
    chk("a1_buf_hold",    tx_buf, 128'h81);
    tick();

    // Two bytes of 0xFF.
    a_req = 1; a_len = 8'd2; a_buf = {16{8'hFF}};
    tick();
    chk("a2_wr",  128'(tx_packet_wr), 128'(1));
    chk("a2_buf", tx_buf, 128'hFFFF);
    chk("a2_txc", 128'(tx_count), 128'(2));
    a_req = 0;
    tick(); tick();

    // Length equal to MAX_LEN is accepted with the whole buffer.
    a_req = 1; a_len = 8'd16; a_buf = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    tick();
    chk("a16_wr",  128'(tx_packet_wr), 128'(1));
    chk("a16_len", 128'(tx_payload_len), 128'(16));
    chk("a16_buf", tx_buf, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    chk("a16_txc", 128'(tx_count), 128'(3));
    a_req = 0;
    tick(); tick();

    // B with length 0 then 17: two rejections, no writes.
    b_req = 1; b_len = 8'd0; b_buf = {16{8'h5A}};
    tick();
    chk("b0_pulse", pulses(), 128'(4'b0001));
    chk("b0_wr",    128'(tx_packet_wr), 128'(0));
    chk("b0_drop",  128'(drop_count), 128'(1));
    b_len = 8'd17;
    tick();
    chk("b_err_clear", pulses(), 128'(0));
    tick();
    chk("b17_pulse", pulses(), 128'(4'b0001));
    chk("b17_wr",    128'(tx_packet_wr), 128'(0));
    chk("b17_drop",  128'(drop_count), 128'(2));
    chk("b17_txc",   128'(tx_count), 128'(3));
    chk("b17_len_hold", 128'(tx_payload_len), 128'(16));
    b_req = 0;
    tick();
    chk("b17_clear", pulses(), 128'(0));

    // IDLE with tx_busy=1 must not arbitrate.
    a_req = 1; a_len = 8'd1; a_buf = {16{8'h81}}; tx_busy = 1;
    tick();
    chk("busy_idle_wr", 128'(tx_packet_wr), 128'(0));
    tick();
    chk("busy_idle_pulse", pulses(), 128'(0));
    tx_busy = 0;
    tick();
    chk("unbusy_wr",  128'(tx_packet_wr), 128'(1));
    chk("unbusy_txc", 128'(tx_count), 128'(4));
    a_req = 0;
    tick(); tick();

    // Fresh reset, both requesting: order A, B, A with 4 busy cycles after each write.
    rst = 0;
    tick();
    rst = 1;
    a_req = 1; a_len = 8'd3; a_buf = {16{8'hA5}};
    b_req = 1; b_len = 8'd4; b_buf = {16{8'hB4}};
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rr_wr",  128'(tx_packet_wr), 128'(1));
      chk("rr_txc", 128'(tx_count), 128'(k + 1));
      if (k == 1) begin
        chk("rr_pulse_b", pulses(), 128'(4'b0100));
        chk("rr_buf_b",   tx_buf, 128'hB4B4_B4B4);
      end else begin
        chk("rr_pulse_a", pulses(), 128'(4'b1000));
        chk("rr_buf_a",   tx_buf, 128'hA5_A5A5);
      end
      if (k < 2) begin
        tx_busy = 1;
        for (int c = 0; c < 4; c++) begin
          tick();
          chk("rr_hold_wr", 128'(tx_packet_wr), 128'(0));
          chk("rr_hold_pulse", pulses(), 128'(0));
        end
        tx_busy = 0;
        tick();
        chk("rr_idle_wr", 128'(tx_packet_wr), 128'(0));
      end
    end

    // Reset while in WAIT with tx_busy=1; A still pending.
    b_req = 0; tx_busy = 1;
    tick(); tick();
    #2 rst = 0;
    #1 chk_all_zero("mid_reset");
    #2 rst = 1; tx_busy = 0;
    tick();
    chk("post_rst_wr",    128'(tx_packet_wr), 128'(1));
    chk("post_rst_pulse", pulses(), 128'(4'b1000));
    chk("post_rst_len",   128'(tx_payload_len), 128'(3));
    chk("post_rst_txc",   128'(tx_count), 128'(1));

    // Continuous A with tx_busy=0: writes exactly 3 cycles apart.
    a_len = 8'd1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("spacing_wr", 128'(tx_packet_wr), 128'((i % 3) == 0));
    end
    chk("spacing_txc", 128'(tx_count), 128'(4));
    a_req = 0;
    tick(); tick();

    // drop_count wraps after 256 rejections.
    rst = 0;
    tick();
    rst = 1;
    a_req = 1; a_len = 8'd0;
    for (int i = 0; i < 255; i++) begin
      tick(); tick();
    end
    chk("drop_255", 128'(drop_count), 128'(8'hFF));
    tick();
    chk("drop_wrap_pulse", pulses(), 128'(4'b0010));
    chk("drop_wrap",       128'(drop_count), 128'(0));
    chk("drop_wrap_txc",   128'(tx_count), 128'(0));
    a_req = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
